sync_pulse_gen: RTL

- Multi-channel successor to the single fixed-length sync pulse generator.
- Each channel turns a one-cycle trigger into a pulse with runtime-programmable delay and length, plus busy/done status.
- Sits between the timing/control FSM and the board sync lines: one channel per external sync/trigger output, all in the bus clock domain.

---
 rtl/sync_pulse_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sync_pulse_gen.sv
// Multi-channel sync pulse generator: each trigger yields a pulse with programmable delay/length.
// Define SYNC_PULSE_GEN_INVERT_EN for active-low sync_out; the timing is the same in both builds.
module sync_pulse_gen #(
    parameter int NUM_CH     = 4,
    parameter int COUNT_BITS = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_CH-1:0]            trig,
    input  logic [NUM_CH*COUNT_BITS-1:0] delay,
    input  logic [NUM_CH*COUNT_BITS-1:0] length,
    input  logic                         retrig,
    output logic [NUM_CH-1:0]            sync_out,
    output logic [NUM_CH-1:0]            busy,
    output logic [NUM_CH-1:0]            done
);

`ifdef SYNC_PULSE_GEN_INVERT_EN
    localparam logic SYNC_IDLE_LVL = 1'b1;
`else
    localparam logic SYNC_IDLE_LVL = 1'b0;
`endif

    localparam logic [COUNT_BITS-1:0] CNT_ZERO = {COUNT_BITS{1'b0}};
    localparam logic [COUNT_BITS-1:0] CNT_ONE  = {{(COUNT_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    state_t                  state_q [NUM_CH];
    state_t                  state_d [NUM_CH];
    logic [COUNT_BITS-1:0]   cnt_q   [NUM_CH];
    logic [COUNT_BITS-1:0]   cnt_d   [NUM_CH];
    logic [COUNT_BITS-1:0]   len_q   [NUM_CH];
    logic [COUNT_BITS-1:0]   len_d   [NUM_CH];
    logic [COUNT_BITS-1:0]   new_dly_s [NUM_CH];
    logic [COUNT_BITS-1:0]   new_len_s [NUM_CH];
    logic [NUM_CH-1:0]       last_s;
    logic [NUM_CH-1:0]       accept_s;
    logic [NUM_CH-1:0]       sync_q, sync_d;
    logic [NUM_CH-1:0]       busy_q, busy_d;
    logic [NUM_CH-1:0]       done_q, done_d;

    // Per-channel next-state, counter and registered-output computation
    always_comb begin
        last_s   = {NUM_CH{1'b0}};
        accept_s = {NUM_CH{1'b0}};
        sync_d   = {NUM_CH{SYNC_IDLE_LVL}};
        busy_d   = {NUM_CH{1'b0}};
        done_d   = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            len_d[i]     = len_q[i];
            new_dly_s[i] = delay[i*COUNT_BITS +: COUNT_BITS];
            new_len_s[i] = length[i*COUNT_BITS +: COUNT_BITS];

            // The final pulse cycle behaves like IDLE for triggers, whatever retrig says.
            last_s[i]   = (state_q[i] == ST_PULSE) && (cnt_q[i] == CNT_ZERO);
            accept_s[i] = trig[i] && ((state_q[i] == ST_IDLE) || last_s[i] || retrig);

            if (accept_s[i]) begin
                len_d[i] = new_len_s[i];
                if (new_len_s[i] == CNT_ZERO) begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = CNT_ZERO;
                end else if (new_dly_s[i] == CNT_ZERO) begin
                    state_d[i] = ST_PULSE;
                    cnt_d[i]   = new_len_s[i] - CNT_ONE;
                end else begin
                    state_d[i] = ST_DELAY;
                    cnt_d[i]   = new_dly_s[i] - CNT_ONE;
                end
            end else begin
                case (state_q[i])
                    ST_DELAY: begin
                        if (cnt_q[i] == CNT_ZERO) begin
                            state_d[i] = ST_PULSE;
                            cnt_d[i]   = len_q[i] - CNT_ONE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_q[i] == CNT_ZERO) begin
                            state_d[i] = ST_IDLE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = CNT_ZERO;
                    end
                endcase
            end

            done_d[i] = last_s[i];
            busy_d[i] = (state_d[i] != ST_IDLE);
            sync_d[i] = (state_d[i] == ST_PULSE) ? ~SYNC_IDLE_LVL : SYNC_IDLE_LVL;
        end
    end

    // State, counters, latched length and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= CNT_ZERO;
                len_q[i]   <= CNT_ZERO;
            end
            sync_q <= {NUM_CH{SYNC_IDLE_LVL}};
            busy_q <= {NUM_CH{1'b0}};
            done_q <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                len_q[i]   <= len_d[i];
            end
            sync_q <= sync_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign sync_out = sync_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
